fixed_residual_restorer: RTL
============================

Name: fixed_residual_restorer

Overview:
- Streaming FLAC FIXED-subframe sample reconstructor. It consumes warm-up samples followed by decoded residuals, and emits reconstructed PCM samples.
- Parametrised successor to the fixed 16-bit, 4096-sample subframe path: sample width, residual width and maximum block size are generic, and the block-size is run-time.
- Adds valid/ready flow control on both sides, a per-block start/done handshake, and error/overflow reporting.
- Sits between the residual (Rice) decoder and the channel decorrelator / output FIFO.

Parameters:
SAMPLE_W, 16, output sample width in bits (signed)
RESID_W, 32, input residual/warm-up width in bits (signed)
BS_W, 16, block-size counter width; maximum block = 2**BS_W-1

Ports:
iClock  in  1  system clock, rising edge
iReset_n  in  1  asynchronous active-low reset
iStart  in  1  one-cycle pulse; latches iOrder and iBlockSize; ignored unless idle
iOrder  in  3  fixed predictor order, 0..4
iBlockSize  in  BS_W  samples in this subframe
iData  in  RESID_W  warm-up sample or residual (signed)
iValid  in  1  iData valid
oReady  out  1  block accepts iData this cycle
oSample  out  SAMPLE_W  reconstructed sample (signed)
oValid  out  1  oSample valid
iReady  in  1  downstream accepts oSample
oBusy  out  1  block in progress
oDone  out  1  one-cycle pulse when the last sample is accepted downstream
oError  out  1  sticky until next iStart: illegal order or blocksize
oOverflow  out  1  sticky until next iStart: result exceeded SAMPLE_W

Behaviour:
- Reset (async assert, sync release): state IDLE; oSample=0, oValid=0, oReady=0, oBusy=0, oDone=0, oError=0, oOverflow=0; history h1..h4=0; counters=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On iStart, clear oError/oOverflow/history and latch order/blocksize.
  - If order>4, or blocksize==0, or blocksize<=order: set oError, stay IDLE, no oDone.
  - Otherwise go to RUN with oBusy=1.
- RUN:
  - Input transfer occurs when iValid && oReady.
  - oReady = (!oValid || iReady).
  - Output register changes only when empty or being accepted; single-stage, no combinational iReady->oValid path.
- Per transfer k (0-based):
  - k<order: value = sign-extended iData (warm-up, verbatim).
  - k>=order: value = iData + pred(order), where:
    - pred0 = 0
    - pred1 = h1
    - pred2 = 2h1 - h2
    - pred3 = 3h1 - 3h2 + h3
    - pred4 = 4h1 - 6h2 + 4h3 - h4
- Arithmetic:
  - Use an internal accumulator of width max(RESID_W, SAMPLE_W+4)+1, signed.
  - oSample = low SAMPLE_W bits of value (two's-complement wrap).
  - If value is outside the SAMPLE_W range, set oOverflow.
  - History shifts h4<=h3, h3<=h2, h2<=h1, h1<=truncated oSample value.
- Latency: output is valid on the cycle after the input transfer; throughput is 1 sample/cycle when iReady=1.
- After the blocksize-th input transfer, deassert oReady and go to DRAIN.
- DRAIN: when the last sample is accepted (oValid && iReady), pulse oDone for 1 cycle, drop oBusy, return to IDLE.
- iStart while RUN/DRAIN: ignored.
- iValid with oReady=0, or in IDLE: data is not consumed.
- Async reset mid-block: immediate return to IDLE, in-flight sample discarded, no oDone.

Decomposition:
- Shared package flac_pkg: FLAC_MAX_FIXED_ORDER=4, state encoding, and the fixed-predictor coefficient constants. Reused by the later LPC restorer.
- One sub-module is natural: fixed_predictor. It is combinational, takes h1..h4 and order, and returns pred at accumulator width.

Test Plan:
- Order 0, blocksize 4, inputs 5,-3,7,0, iReady=1 -> oSample 5,-3,7,0 on consecutive cycles, each 1 cycle after its input; oDone pulses once after the 4th.
- Order 1, blocksize 4, inputs 100,1,2,3 -> 100,101,103,106. Order 2, blocksize 4, inputs 10,20,0,0 -> 10,20,30,40.
- Order 4, blocksize 6, inputs 1,4,9,16,0,0 -> 1,4,9,16,25,36. Repeat with iReady toggling 1/0 every cycle -> same sequence, no loss or duplication, and oReady=0 whenever oValid && !iReady.
- iStart with order=5 -> oError=1, oBusy stays 0, no oValid. iStart with order=3, blocksize=3 -> oError=1. A subsequent valid iStart clears oError.
- SAMPLE_W=16, order 1, blocksize 2, inputs 32767,1 -> oSample 32767 then -32768; oOverflow=1 until next iStart.
- Assert iReset_n low after 2 of 8 samples -> all outputs 0 in the same cycle. A new block after release decodes correctly from clean history, with no spurious oDone.

Source files
------------

// File: rtl/flac_pkg.sv
// Shared FLAC subframe definitions: fixed-predictor limits, FSM encoding
// and the fixed-predictor coefficients (also used by the LPC restorer).
package flac_pkg;

  localparam int FLAC_MAX_FIXED_ORDER = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Coefficient applied to history tap h<tap> (tap 1..4) for a given order.
  // These are the signed binomial rows (1), (2,-1), (3,-3,1), (4,-6,4,-1).
  function automatic int fixed_coef(input int order, input int tap);
    int c;
    c = 0;
    case (order)
      1: c = (tap == 1) ? 1 : 0;
      2: case (tap)
           1: c = 2;
           2: c = -1;
           default: c = 0;
         endcase
      3: case (tap)
           1: c = 3;
           2: c = -3;
           3: c = 1;
           default: c = 0;
         endcase
      4: case (tap)
           1: c = 4;
           2: c = -6;
           3: c = 4;
           4: c = -1;
           default: c = 0;
         endcase
      default: c = 0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fixed_predictor.sv
// Combinational FLAC fixed predictor: pred(order) from the last four
// reconstructed samples, evaluated at accumulator width so it never wraps.
module fixed_predictor
  import flac_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 33
) (
  input  logic        [2:0]          order,
  input  logic signed [SAMPLE_W-1:0] h1,
  input  logic signed [SAMPLE_W-1:0] h2,
  input  logic signed [SAMPLE_W-1:0] h3,
  input  logic signed [SAMPLE_W-1:0] h4,
  output logic signed [ACC_W-1:0]    pred
);

  logic signed [ACC_W-1:0] hx     [1:4];
  logic signed [ACC_W-1:0] pred_o [0:FLAC_MAX_FIXED_ORDER];

  assign hx[1] = ACC_W'(h1);
  assign hx[2] = ACC_W'(h2);
  assign hx[3] = ACC_W'(h3);
  assign hx[4] = ACC_W'(h4);

  // One constant-coefficient sum per order; the order mux below picks one.
  for (genvar o = 0; o <= FLAC_MAX_FIXED_ORDER; o++) begin : g_order
    localparam logic signed [ACC_W-1:0] C1 = ACC_W'(fixed_coef(o, 1));
    localparam logic signed [ACC_W-1:0] C2 = ACC_W'(fixed_coef(o, 2));
    localparam logic signed [ACC_W-1:0] C3 = ACC_W'(fixed_coef(o, 3));
    localparam logic signed [ACC_W-1:0] C4 = ACC_W'(fixed_coef(o, 4));
    assign pred_o[o] = C1 * hx[1] + C2 * hx[2] + C3 * hx[3] + C4 * hx[4];
  end

  // Select the prediction for the latched order; illegal orders predict 0.
  always_comb begin
    pred = '0;
    case (order)
      3'd0:    pred = pred_o[0];
      3'd1:    pred = pred_o[1];
      3'd2:    pred = pred_o[2];
      3'd3:    pred = pred_o[3];
      3'd4:    pred = pred_o[4];
      default: pred = '0;
    endcase
  end

endmodule

// File: rtl/fixed_residual_restorer.sv
// Streaming FLAC FIXED-subframe reconstructor: warm-up samples pass through,
// later residuals are added to the fixed prediction from the output history.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for iStart; validates order/blocksize
// ST_RUN   | accepting warm-ups/residuals, one output register stage
// ST_DRAIN | all inputs taken; waiting for the last sample to be accepted
module fixed_residual_restorer
  import flac_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int RESID_W  = 32,
  parameter int BS_W     = 16
) (
  input  logic                       iClock,
  input  logic                       iReset_n,
  input  logic                       iStart,
  input  logic        [2:0]          iOrder,
  input  logic        [BS_W-1:0]     iBlockSize,
  input  logic signed [RESID_W-1:0]  iData,
  input  logic                       iValid,
  output logic                       oReady,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oValid,
  input  logic                       iReady,
  output logic                       oBusy,
  output logic                       oDone,
  output logic                       oError,
  output logic                       oOverflow
);

  localparam int ACC_W = ((RESID_W > SAMPLE_W + 4) ? RESID_W : SAMPLE_W + 4) + 1;

  logic        [1:0]          state;
  logic        [2:0]          order_q;
  logic        [2:0]          warm_left;
  logic        [BS_W-1:0]     remain;
  logic signed [SAMPLE_W-1:0] h1, h2, h3, h4;
  logic signed [ACC_W-1:0]    pred, data_ext, value, value_wrap;
  logic                       warm, xfer, value_ovf, start_bad;

  fixed_predictor #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_pred (
    .order (order_q),
    .h1    (h1),
    .h2    (h2),
    .h3    (h3),
    .h4    (h4),
    .pred  (pred)
  );

  assign data_ext   = ACC_W'(iData);
  assign warm       = (warm_left != 3'd0);
  assign value      = warm ? data_ext : data_ext + pred;
  // Overflow: the value does not survive truncation to SAMPLE_W and re-extension.
  assign value_wrap = ACC_W'($signed(value[SAMPLE_W-1:0]));
  assign value_ovf  = (value != value_wrap);
  assign start_bad  = (iOrder > 3'(FLAC_MAX_FIXED_ORDER)) || (iBlockSize == '0) ||
                      (iBlockSize <= BS_W'(iOrder));

  assign oReady = (state == ST_RUN) && (!oValid || iReady);
  assign xfer   = iValid && oReady;
  assign oBusy  = (state != ST_IDLE);

  // Block sequencing, output register, history shift and sticky flags.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state     <= ST_IDLE;
      order_q   <= '0;
      warm_left <= '0;
      remain    <= '0;
      h1        <= '0;
      h2        <= '0;
      h3        <= '0;
      h4        <= '0;
      oSample   <= '0;
      oValid    <= 1'b0;
      oDone     <= 1'b0;
      oError    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            order_q   <= iOrder;
            warm_left <= iOrder;
            remain    <= iBlockSize;
            h1        <= '0;
            h2        <= '0;
            h3        <= '0;
            h4        <= '0;
            oOverflow <= 1'b0;
            oError    <= start_bad;
            if (!start_bad) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (oValid && iReady) oValid <= 1'b0;
          if (xfer) begin
            oSample <= value[SAMPLE_W-1:0];
            oValid  <= 1'b1;
            h4      <= h3;
            h3      <= h2;
            h2      <= h1;
            h1      <= value[SAMPLE_W-1:0];
            if (value_ovf) oOverflow <= 1'b1;
            if (warm) warm_left <= warm_left - 3'd1;
            remain <= remain - BS_W'(1);
            if (remain == BS_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (oValid && iReady) begin
            oValid <= 1'b0;
            oDone  <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
